// File: rtl/led_sequencer.sv
// LED pattern sequencer: a debounced button cycles through four LED patterns,
// and a free-running prescaler advances the active pattern one step at a time.
module led_sequencer #(
    parameter int TICK_DIV = 12000000,
    parameter int DEBOUNCE = 240000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       hold,
    output logic [3:0] leds,
    output logic [1:0] mode
);

    localparam int PCNT_W = $clog2(TICK_DIV);
    localparam int DCNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        MODE_ALTERNATE = 2'd0,
        MODE_CHASE     = 2'd1,
        MODE_BOUNCE    = 2'd2,
        MODE_BINARY    = 2'd3
    } mode_e;

    localparam logic [3:0] ALTERNATE_INIT = 4'b0101;
    localparam logic [3:0] CHASE_INIT     = 4'b0001;
    localparam logic [3:0] BOUNCE_INIT    = 4'b0001;
    localparam logic [3:0] BINARY_INIT    = 4'b0000;

    function automatic logic [3:0] init_pattern(input mode_e m);
        logic [3:0] p;
        case (m)
            MODE_ALTERNATE: p = ALTERNATE_INIT;
            MODE_CHASE:     p = CHASE_INIT;
            MODE_BOUNCE:    p = BOUNCE_INIT;
            default:        p = BINARY_INIT;
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Button synchronizer and debouncer
    // ------------------------------------------------------------------
    logic [1:0]        sync_q, sync_d;
    logic              btn_s;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              deb_q, deb_d;           // debounced button level
    logic              deb_prev_q, deb_prev_d; // debounced level one cycle earlier
    logic              press;

    assign btn_s = sync_q[1];

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sync_d     = {sync_q[0], btn};
        dcnt_d     = '0;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        if (btn_s != deb_q) begin
            if (dcnt_q == DCNT_LAST) begin
                deb_d = btn_s;
            end else begin
                dcnt_d = dcnt_q + DCNT_W'(1);
            end
        end
    end

    // Only the rising edge of the debounced level counts as a press.
    assign press = deb_q & ~deb_prev_q;

    // ------------------------------------------------------------------
    // Step prescaler
    // ------------------------------------------------------------------
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              step;

    assign step = (pcnt_q == PCNT_LAST) && !hold;

    always_comb begin
        pcnt_d = pcnt_q;
        if (press) begin
            pcnt_d = '0;
        end else if (!hold) begin
            pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pattern FSM: state register / next-state / output
    // ------------------------------------------------------------------
    mode_e      mode_q, mode_d;
    logic [3:0] leds_q, leds_d;
    logic       dir_up_q, dir_up_d;

    // NOTE: the reset is synchronous and every flop here is a control or
    // datapath register (no memories), so all of them are cleared.
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // flop samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q     <= '0;
            dcnt_q     <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            pcnt_q     <= '0;
            mode_q     <= MODE_ALTERNATE;
            leds_q     <= ALTERNATE_INIT;
            dir_up_q   <= 1'b1;
        end else begin
            sync_q     <= sync_d;
            dcnt_q     <= dcnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            pcnt_q     <= pcnt_d;
            mode_q     <= mode_d;
            leds_q     <= leds_d;
            dir_up_q   <= dir_up_d;
        end
    end

    always_comb begin
        mode_d   = mode_q;
        leds_d   = leds_q;
        dir_up_d = dir_up_q;
        if (press) begin
            case (mode_q)
                MODE_ALTERNATE: mode_d = MODE_CHASE;
                MODE_CHASE:     mode_d = MODE_BOUNCE;
                MODE_BOUNCE:    mode_d = MODE_BINARY;
                default:        mode_d = MODE_ALTERNATE;
            endcase
            leds_d   = init_pattern(mode_d);
            dir_up_d = 1'b1;
        end else if (step) begin
            case (mode_q)
                MODE_ALTERNATE: leds_d = ~leds_q;
                MODE_CHASE:     leds_d = {leds_q[2:0], leds_q[3]};
                MODE_BOUNCE: begin
                    // Reversal happens on the end position itself, so the
                    // end LED is shown for exactly one step.
                    if (dir_up_q) begin
                        if (leds_q[3]) begin
                            leds_d   = leds_q >> 1;
                            dir_up_d = 1'b0;
                        end else begin
                            leds_d = leds_q << 1;
                        end
                    end else begin
                        if (leds_q[0]) begin
                            leds_d   = leds_q << 1;
                            dir_up_d = 1'b1;
                        end else begin
                            leds_d = leds_q >> 1;
                        end
                    end
                end
                default:        leds_d = leds_q + 4'd1;
            endcase
        end
    end

    always_comb begin
        leds = leds_q;
        mode = mode_q;
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized and directed bench for led_sequencer, checked against a
// sequence-index reference model of the LED patterns.
module tb_led_sequencer;

    localparam int T = 4;
    localparam int D = 3;
    localparam logic [3:0] BOUNCE_TAB [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
    localparam logic [3:0] BOUNCE_SEQ [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       hold;
    logic [3:0] leds;
    logic [1:0] mode;

    always #5 clk = ~clk;

    led_sequencer #(.TICK_DIV(T), .DEBOUNCE(D)) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .hold (hold),
        .leds (leds),
        .mode (mode)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    string tag;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pattern = f(mode, number of steps since the pattern was loaded).
    int m_mode, m_idx, m_phase, m_run;
    bit m_level, m_level_prev, m_b1, m_b2;

    function automatic logic [3:0] model_leds();
        case (m_mode)
            0:       return (m_idx % 2 == 1) ? 4'hA : 4'h5;
            1:       return 4'(1 << (m_idx % 4));
            2:       return BOUNCE_TAB[m_idx % 6];
            default: return 4'(m_idx % 16);
        endcase
    endfunction

    function automatic logic [3:0] init_of(input int m);
        case (m)
            0:       return 4'h5;
            1:       return 4'h1;
            2:       return 4'h1;
            default: return 4'h0;
        endcase
    endfunction

    task automatic model_edge(input bit b, input bit h, input bit r);
        bit press;
        bit bs;
        bit old_level;
        if (!r) begin
            m_mode = 0; m_idx = 0; m_phase = 0; m_run = 0;
            m_level = 0; m_level_prev = 0; m_b1 = 0; m_b2 = 0;
            return;
        end
        press     = m_level && !m_level_prev;
        bs        = m_b2;
        old_level = m_level;
        // Level changes after D consecutive cycles of disagreement.
        if (bs != m_level) begin
            m_run++;
            if (m_run == D) begin
                m_level = bs;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        m_level_prev = old_level;
        m_b2 = m_b1;
        m_b1 = b;
        if (press) begin
            m_mode  = (m_mode + 1) % 4;
            m_idx   = 0;
            m_phase = 0;
        end else if (!h) begin
            if (m_phase == T - 1) m_idx++;
            m_phase = (m_phase + 1) % T;
        end
    endtask

    task automatic cyc(input bit b, input bit h, input bit r);
        btn  = b;
        hold = h;
        rst  = r;
        @(posedge clk);
        model_edge(b, h, r);
        #1;
        check({tag, ".leds"}, 8'(leds), 8'(model_leds()));
        check({tag, ".mode"}, 8'(mode), 8'(m_mode));
    endtask

    int seg_len;
    bit rb, rh, rr;

    initial begin
        rst = 1'b0; btn = 1'b0; hold = 1'b0;

        tag = "reset";
        repeat (3) cyc(0, 0, 0);
        check("reset_leds", 8'(leds), 8'h05);
        check("reset_mode", 8'(mode), 8'h00);

        tag = "alt";
        for (int i = 1; i <= 12; i++) begin
            cyc(0, 0, 1);
            if (i % 4 == 0) check("alt_step", 8'(leds), (i % 8 == 4) ? 8'h0A : 8'h05);
        end

        tag = "glitch";
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        repeat (8) cyc(0, 0, 1);
        check("glitch_mode", 8'(mode), 8'h00);

        tag = "press";
        for (int p = 0; p < 4; p++) begin
            for (int j = 1; j <= 10; j++) begin
                cyc(1, 0, 1);
                if (j == 6) begin
                    check("press_mode", 8'(mode), 8'((p + 1) % 4));
                    check("press_init", 8'(leds), 8'(init_of((p + 1) % 4)));
                end
            end
            repeat (10) cyc(0, 0, 1);
        end

        // Into mode 1, then mode 2 and watch the bounce from its load.
        tag = "to_chase";
        repeat (10) cyc(1, 0, 1);
        repeat (10) cyc(0, 0, 1);
        tag = "bounce";
        repeat (6) cyc(1, 0, 1);
        check("bounce_init", 8'(leds), 8'(BOUNCE_SEQ[0]));
        for (int i = 1; i <= 28; i++) begin
            cyc(i <= 4, 0, 1);
            if (i % 4 == 0) check("bounce_seq", 8'(leds), 8'(BOUNCE_SEQ[i / 4]));
        end

        tag = "binary";
        repeat (6) cyc(1, 0, 1);
        check("binary_mode", 8'(mode), 8'h03);
        check("binary_init", 8'(leds), 8'h00);
        repeat (4) cyc(1, 0, 1);
        repeat (10) cyc(0, 0, 1);
        check("binary_pre_hold", 8'(leds), 8'h03);
        tag = "hold";
        repeat (20) begin
            cyc(0, 1, 1);
            check("hold_frozen", 8'(leds), 8'h03);
        end
        tag = "resume";
        for (int i = 1; i <= 52; i++) begin
            cyc(0, 0, 1);
            if (i == 2)  check("resume_step", 8'(leds), 8'h04);
            if (i == 46) check("wrap_top", 8'(leds), 8'h0F);
            if (i == 50) check("wrap_zero", 8'(leds), 8'h00);
        end

        // Line up the press event with the step cycle.
        tag = "align";
        for (int i = 0; i < 8 && m_phase != 2; i++) cyc(0, 0, 1);
        check("align_phase", 8'(m_phase), 8'h02);
        repeat (6) cyc(1, 0, 1);
        check("collide_mode", 8'(mode), 8'h00);
        check("collide_leds", 8'(leds), 8'h05);
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 0, 1);
            if (i == 4) check("post_press_step", 8'(leds), 8'h0A);
        end
        tag = "midreset";
        cyc(0, 0, 0);
        check("midreset_leds", 8'(leds), 8'h05);
        check("midreset_mode", 8'(mode), 8'h00);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 1);
            check("after_reset_step", 8'(leds), (i < 4) ? 8'h05 : 8'h0A);
        end

        tag = "random";
        seg_len = 0;
        rb = 0; rh = 0;
        for (int i = 0; i < 800; i++) begin
            if (seg_len == 0) begin
                rb      = 1'($urandom_range(0, 1));
                seg_len = $urandom_range(1, 9);
            end
            seg_len--;
            if ($urandom_range(0, 7) == 0) rh = ~rh;
            rr = ($urandom_range(0, 63) != 0);
            cyc(rb, rh, rr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 12000000: clk cycles per pattern step (legal >= 2).
REQ-002 Parameter DEBOUNCE, default 240000: consecutive stable cycles before the debounced button changes (legal >= 1).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 btn  input  1  raw mode-advance button, asynchronous to clk, active-high.
REQ-006 hold  input  1  synchronous; 1 = freeze pattern and prescaler.
REQ-007 leds  output  4  registered LED pattern.
REQ-008 mode  output  2  registered current pattern mode.

Function
REQ-009 btn SHALL pass through a 2-flop synchronizer; btn_s is the second flop's output.
REQ-010 Debouncer: counter dcnt, level btn_d; if btn_s == btn_d then dcnt <= 0; else dcnt increments, and on the cycle dcnt reaches DEBOUNCE-1, btn_d <= btn_s and dcnt <= 0.
REQ-011 Glitch shorter than DEBOUNCE cycles (after sync) SHALL leave btn_d unchanged.
REQ-012 Press event = btn_d rising (registered btn_d_q == 0, btn_d == 1); release events SHALL be ignored.
REQ-013 On press event mode <= mode + 1 modulo 4 (3 -> 0); leds <= initial pattern of the new mode in the same cycle; prescaler and bounce direction cleared.
REQ-014 Prescaler pcnt counts 0..TICK_DIV-1 and wraps; step pulse when pcnt == TICK_DIV-1; held (not incremented) while hold == 1.
REQ-015 On step pulse (hold == 0, no press event) leds SHALL advance one position per mode:
REQ-016 Mode 0 ALTERNATE: initial 4'b0101; 0101 <-> 1010.
REQ-017 Mode 1 CHASE: initial 4'b0001; rotate left, 1000 -> 0001.
REQ-018 Mode 2 BOUNCE: initial 4'b0001, direction up; shift left while up, reverse at 1000; shift right while down, reverse at 0001; sequence 0001,0010,0100,1000,0100,0010,0001,0010...
REQ-019 Mode 3 BINARY: initial 4'b0000; leds <= leds + 1, 1111 -> 0000 wrap.
REQ-020 Press event and step pulse in same cycle: press wins, step discarded, pcnt <= 0.
REQ-021 Press event while hold == 1: mode still advances and initial pattern loads; pattern then frozen until hold == 0.
REQ-022 hold SHALL NOT affect synchronizer or debouncer.
REQ-023 leds SHALL be one-hot in modes 1 and 2 at all times after reset.

Reset
REQ-024 While rst == 0 at a clk edge: mode = 0, leds = 4'b0101, pcnt = 0, dcnt = 0, btn_d = btn_d_q = 0, sync flops = 0, direction = up.
REQ-025 Reset mid-step or mid-debounce SHALL discard all progress; first step after release occurs TICK_DIV cycles after the first cycle with rst == 1 (hold == 0).
REQ-026 Outputs SHALL be valid in the first cycle after reset deasserts; no X on leds/mode.

Verification (TICK_DIV=4, DEBOUNCE=3)
REQ-027 Reset, hold=0, btn=0, run 12 cycles -> leds 0101,1010,0101 changing every 4 cycles; mode stays 0.
REQ-028 btn high 2 cycles then low -> no press; mode remains 0, leds unaffected.
REQ-029 Four clean presses (btn high 10 cycles each, 10 low between) -> mode 1,2,3,0; leds loads 0001,0001,0000,0101 on each press cycle.
REQ-030 Mode 2, run 28 cycles -> leds 0001,0010,0100,1000,0100,0010,0001,0010 one per step.
REQ-031 Mode 3, hold=1 for 20 cycles then 0 -> leds frozen during hold; resumes counting, wraps 1111 -> 0000.
REQ-032 Press aligned with pcnt == 3, then rst=0 for 1 cycle mid-count -> press wins (new mode initial pattern, no step); after reset mode=0, leds=0101, next step exactly 4 cycles later.
